// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: program counter with hold/inc/jump/branch and an optional return-address stack.
// Define PC_SEQUENCER_CALL_STACK_EN to build the stack (CALL pushes, RET pops). Rev 1.0
module pc_sequencer #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter int              STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic [WIDTH-1:0]                 target,
  input  logic [WIDTH-1:0]                 offset,
  output logic [WIDTH-1:0]                 pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             fault
);

  localparam int CW = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  logic [WIDTH-1:0] pc_next;
  logic             fault_next;
  logic [WIDTH-1:0] pc_plus1;

  assign pc_plus1 = pc_out + WIDTH'(1);

`ifdef PC_SEQUENCER_CALL_STACK_EN
  localparam int             AW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(STACK_DEPTH);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;

  // Entries live at indices 0..count-1; the top is the last written one.
  assign push_idx = AW'(stack_count);
  assign top_idx  = AW'(stack_count - CW'(1));
`endif

  always_comb begin
    pc_next    = pc_out;
    fault_next = 1'b0;
`ifdef PC_SEQUENCER_CALL_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif
    if (en) begin
      case (op)
        OP_HOLD:   pc_next = pc_out;
        OP_INC:    pc_next = pc_plus1;
        OP_JUMP:   pc_next = target;
        OP_BRANCH: pc_next = pc_out + offset;
        OP_CALL: begin
`ifdef PC_SEQUENCER_CALL_STACK_EN
          if (stack_full) begin
            fault_next = 1'b1;
          end else begin
            push    = 1'b1;
            pc_next = target;
          end
`else
          pc_next = target;
`endif
        end
        OP_RET: begin
`ifdef PC_SEQUENCER_CALL_STACK_EN
          if (stack_empty) begin
            fault_next = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_next = stack_mem[top_idx];
          end
`else
          fault_next = 1'b1;
`endif
        end
        default:   fault_next = 1'b1;
      endcase
    end
  end

`ifdef PC_SEQUENCER_CALL_STACK_EN
  always_comb begin
    count_next = stack_count;
    if (push)     count_next = stack_count + CW'(1);
    else if (pop) count_next = stack_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stack_count <= '0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
    end else begin
      stack_count <= count_next;
      stack_full  <= (count_next == DEPTH_C);
      stack_empty <= (count_next == '0);
    end
  end

  // Storage carries no reset; a reset only clears the count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_mem[push_idx] <= pc_plus1;
    end
  end
`else
  assign stack_count = '0;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out <= RESET_VEC;
      fault  <= 1'b0;
    end else begin
      pc_out <= pc_next;
      fault  <= fault_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer: directed vectors with a queued scoreboard for pc_sequencer.
module tb_pc_sequencer;

  localparam int CW = $clog2(4 + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [7:0]    target = 8'h00;
  logic [7:0]    offset = 8'h00;
  logic [7:0]    pc_out;
  logic [CW-1:0] stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic [7:0]    pc;
    logic [CW-1:0] cnt;
    logic          flt;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer #(.WIDTH(8), .RESET_VEC(8'h10), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .offset(offset),
    .pc_out(pc_out), .stack_count(stack_count), .stack_full(stack_full),
    .stack_empty(stack_empty), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", name, field, got, want);
    end
  endtask

  // Monitor: compares one expectation per clock, one time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "pc", pc_out, e.pc);
        chk(e.name, "count", 8'(stack_count), 8'(e.cnt));
        chk(e.name, "fault", 8'(fault), 8'(e.flt));
        chk(e.name, "full", 8'(stack_full), 8'(e.cnt == CW'(4)));
        chk(e.name, "empty", 8'(stack_empty), 8'(e.cnt == CW'(0)));
      end
    end
  end

  task automatic step(input string name, input logic r, input logic e, input logic [2:0] o,
                      input logic [7:0] t, input logic [7:0] off,
                      input logic [7:0] xpc, input logic [CW-1:0] xcnt, input logic xf);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; op = o; target = t; offset = off;
    x.name = name; x.pc = xpc; x.cnt = xcnt; x.flt = xf;
    exp_q.push_back(x);
  endtask

  initial begin
    step("reset",      1, 1, 3'b001, 8'h00, 8'h00, 8'h10, 0, 0);
    step("inc1",       0, 1, 3'b001, 8'h00, 8'h00, 8'h11, 0, 0);
    step("inc2",       0, 1, 3'b001, 8'h00, 8'h00, 8'h12, 0, 0);
    step("inc3",       0, 1, 3'b001, 8'h00, 8'h00, 8'h13, 0, 0);
    step("jump_ff",    0, 1, 3'b010, 8'hFF, 8'h00, 8'hFF, 0, 0);
    step("inc_wrap",   0, 1, 3'b001, 8'h00, 8'h00, 8'h00, 0, 0);
    step("jump_10",    0, 1, 3'b010, 8'h10, 8'h00, 8'h10, 0, 0);
    step("branch_neg", 0, 1, 3'b011, 8'h00, 8'hFE, 8'h0E, 0, 0);
    step("jump_a5",    0, 1, 3'b010, 8'hA5, 8'h00, 8'hA5, 0, 0);
    step("branch_ovf", 0, 1, 3'b011, 8'h00, 8'h70, 8'h15, 0, 0);
    step("stall1",     0, 0, 3'b001, 8'h00, 8'h00, 8'h15, 0, 0);
    step("stall2",     0, 0, 3'b001, 8'h00, 8'h00, 8'h15, 0, 0);
    step("stall3",     0, 0, 3'b001, 8'h00, 8'h00, 8'h15, 0, 0);
    step("illegal7",   0, 1, 3'b111, 8'h00, 8'h00, 8'h15, 0, 1);
    step("hold",       0, 1, 3'b000, 8'h00, 8'h00, 8'h15, 0, 0);
    step("illegal6",   0, 1, 3'b110, 8'h00, 8'h00, 8'h15, 0, 1);
    step("stall_ill",  0, 0, 3'b111, 8'h00, 8'h00, 8'h15, 0, 0);
    step("jump_20",    0, 1, 3'b010, 8'h20, 8'h00, 8'h20, 0, 0);
`ifdef PC_SEQUENCER_CALL_STACK_EN
    step("call_80",    0, 1, 3'b100, 8'h80, 8'h00, 8'h80, 1, 0);
    step("call_90",    0, 1, 3'b100, 8'h90, 8'h00, 8'h90, 2, 0);
    step("ret_81",     0, 1, 3'b101, 8'h00, 8'h00, 8'h81, 1, 0);
    step("ret_21",     0, 1, 3'b101, 8'h00, 8'h00, 8'h21, 0, 0);
    step("ret_empty",  0, 1, 3'b101, 8'h00, 8'h00, 8'h21, 0, 1);
    step("call_30",    0, 1, 3'b100, 8'h30, 8'h00, 8'h30, 1, 0);
    step("call_40",    0, 1, 3'b100, 8'h40, 8'h00, 8'h40, 2, 0);
    step("call_50",    0, 1, 3'b100, 8'h50, 8'h00, 8'h50, 3, 0);
    step("call_60",    0, 1, 3'b100, 8'h60, 8'h00, 8'h60, 4, 0);
    step("call_full",  0, 1, 3'b100, 8'h70, 8'h00, 8'h60, 4, 1);
    step("stall_call", 0, 0, 3'b100, 8'h70, 8'h00, 8'h60, 4, 0);
    step("ret_51",     0, 1, 3'b101, 8'h00, 8'h00, 8'h51, 3, 0);
    step("ret_41",     0, 1, 3'b101, 8'h00, 8'h00, 8'h41, 2, 0);
    step("rst_call",   1, 1, 3'b100, 8'h99, 8'h00, 8'h10, 0, 0);
    step("ret_postrst",0, 1, 3'b101, 8'h00, 8'h00, 8'h10, 0, 1);
`else
    step("call_jump",  0, 1, 3'b100, 8'h80, 8'h00, 8'h80, 0, 0);
    step("ret_illegal",0, 1, 3'b101, 8'h00, 8'h00, 8'h80, 0, 1);
    step("rst_call",   1, 1, 3'b100, 8'h99, 8'h00, 8'h10, 0, 0);
    step("ret_postrst",0, 1, 3'b101, 8'h00, 8'h00, 8'h10, 0, 1);
`endif
    step("inc_postrst",0, 1, 3'b001, 8'h00, 8'h00, 8'h11, 0, 0);
    step("hold_end",   0, 1, 3'b000, 8'h00, 8'h00, 8'h11, 0, 0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
